// File: rtl/oam_dma_engine.sv
// oam_dma_engine
// Sprite DMA engine. A CPU write of page XX to TRIGGER_ADDR halts the CPU and
// takes over the mem_ctrl bus. The engine then copies bytes XX00..XXFF into
// sprite RAM. Each byte is one read followed by one write to OAM_DATA_ADDR.
// When the last byte is done, the bus is handed back.
//
// Optional feature, enabled by defining the macro OAM_DMA_CYCLE_EXACT_EN:
// an ALIGN state after START. It lasts 1 or 2 cycles, depending on a parity
// bit that toggles every clock.
//
// Ports:
//   clk, rst       clock and asynchronous active-low reset
//   cpu_addr_in    snooped CPU address
//   cpu_data_in    snooped CPU write data (source page on a trigger)
//   cpu_write_en   snooped CPU write strobe
//   mem_data_in    read data returned by mem_ctrl
//   mem_busy       mem_ctrl busy; strobes are held off while high
//   dma_bus_sel    DMA owns the mem_ctrl bus
//   dma_halt       CPU halt request
//   dma_addr       DMA bus address
//   dma_data_out   DMA write data
//   dma_read_en    single-cycle read strobe
//   dma_write_en   single-cycle write strobe
//   dma_busy       transfer in progress (START..DONE)
//   dma_done       single-cycle pulse in DONE
//
// All outputs are registered. Each strobe is decided from the current state
// and mem_busy, and it becomes visible in the following cycle.
module oam_dma_engine #(
  parameter int          READ_LATENCY  = 1,
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_write_en,
  input  logic [7:0]  mem_data_in,
  input  logic        mem_busy,
  output logic        dma_bus_sel,
  output logic        dma_halt,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_data_out,
  output logic        dma_read_en,
  output logic        dma_write_en,
  output logic        dma_busy,
  output logic        dma_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_WT    = 3'd4;
  localparam logic [2:0] S_WR    = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
`ifdef OAM_DMA_CYCLE_EXACT_EN
  localparam logic [2:0] S_ALIGN = 3'd2;
`endif

  // WT lasts READ_LATENCY cycles, so the counter counts down from latency-1.
  localparam logic [1:0] WAIT_LOAD = 2'(READ_LATENCY - 1);

  logic [2:0]  state_r, state_s;
  logic [7:0]  page_r, page_s;
  logic [7:0]  index_r, index_s;
  logic [1:0]  wait_r, wait_s;
  logic [7:0]  byte_r, byte_s;
  logic        wr_first_r, wr_first_s;
  logic [15:0] addr_s;
  logic [7:0]  data_s;
  logic        rd_s, wr_s, active_s;

`ifdef OAM_DMA_CYCLE_EXACT_EN
  logic parity_r;
  logic align_r, align_s;

  // Free-running get/put parity, toggling every clock from reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_r <= 1'b0;
    end else begin
      parity_r <= ~parity_r;
    end
  end
`endif

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_s    = state_r;
    page_s     = page_r;
    index_s    = index_r;
    wait_s     = wait_r;
    byte_s     = byte_r;
    wr_first_s = wr_first_r;
    addr_s     = dma_addr;
    data_s     = dma_data_out;
    rd_s       = 1'b0;
    wr_s       = 1'b0;
`ifdef OAM_DMA_CYCLE_EXACT_EN
    align_s    = align_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (cpu_write_en && (cpu_addr_in == TRIGGER_ADDR)) begin
          page_s  = cpu_data_in;
          index_s = 8'd0;
          state_s = S_START;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_START: begin
        index_s = 8'd0;
`ifdef OAM_DMA_CYCLE_EXACT_EN
        // align_r is one when the parity during the first ALIGN cycle is odd.
        align_s = ~parity_r;
        state_s = S_ALIGN;
`else
        state_s = S_RD;
`endif
      end
`ifdef OAM_DMA_CYCLE_EXACT_EN
      S_ALIGN: begin
        if (align_r) begin
          align_s = 1'b0;
          state_s = S_ALIGN;
        end else begin
          state_s = S_RD;
        end
      end
`endif
      S_RD: begin
        if (mem_busy) begin
          state_s = S_RD;
        end else begin
          addr_s  = {page_r, index_r};
          rd_s    = 1'b1;
          wait_s  = WAIT_LOAD;
          state_s = S_WT;
        end
      end
      S_WT: begin
        if (wait_r == 2'd0) begin
          wr_first_s = 1'b1;
          state_s    = S_WR;
        end else begin
          wait_s = wait_r - 2'd1;
        end
      end
      S_WR: begin
        // Read data is valid in the first WR cycle. Latch it there so that
        // a mem_busy stall cannot lose it.
        if (wr_first_r) begin
          byte_s     = mem_data_in;
          wr_first_s = 1'b0;
        end else begin
          byte_s = byte_r;
        end
        if (mem_busy) begin
          state_s = S_WR;
        end else begin
          addr_s = OAM_DATA_ADDR;
          data_s = wr_first_r ? mem_data_in : byte_r;
          wr_s   = 1'b1;
          if (index_r == 8'hFF) begin
            state_s = S_DONE;
          end else begin
            index_s = index_r + 8'd1;
            state_s = S_RD;
          end
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    active_s = (state_s != S_IDLE);
    if (!active_s) begin
      addr_s = 16'd0;
      data_s = 8'd0;
    end else begin
      addr_s = addr_s;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      page_r       <= 8'd0;
      index_r      <= 8'd0;
      wait_r       <= 2'd0;
      byte_r       <= 8'd0;
      wr_first_r   <= 1'b0;
      dma_bus_sel  <= 1'b0;
      dma_halt     <= 1'b0;
      dma_addr     <= 16'd0;
      dma_data_out <= 8'd0;
      dma_read_en  <= 1'b0;
      dma_write_en <= 1'b0;
      dma_busy     <= 1'b0;
      dma_done     <= 1'b0;
    end else begin
      state_r      <= state_s;
      page_r       <= page_s;
      index_r      <= index_s;
      wait_r       <= wait_s;
      byte_r       <= byte_s;
      wr_first_r   <= wr_first_s;
      dma_bus_sel  <= active_s;
      dma_halt     <= active_s;
      dma_addr     <= addr_s;
      dma_data_out <= data_s;
      dma_read_en  <= rd_s;
      dma_write_en <= wr_s;
      dma_busy     <= active_s;
      dma_done     <= (state_s == S_DONE);
    end
  end

`ifdef OAM_DMA_CYCLE_EXACT_EN
  // Remaining ALIGN cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      align_r <= 1'b0;
    end else begin
      align_r <= align_s;
    end
  end
`endif

endmodule

// File: tb/tb_oam_dma_engine.sv
// Scoreboard bench for oam_dma_engine (READ_LATENCY=1, default build).
module tb_oam_dma_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr_in = 16'd0;
  logic [7:0]  cpu_data_in = 8'd0;
  logic        cpu_write_en = 1'b0;
  logic [7:0]  mem_data_in = 8'd0;
  logic        mem_busy = 1'b0;
  logic        dma_bus_sel, dma_halt, dma_read_en, dma_write_en, dma_busy, dma_done;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_out;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int halt_cnt = 0;
  int last_halt = 0;
  logic busy_q = 1'b0;

  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];

  oam_dma_engine #(.READ_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in), .cpu_write_en(cpu_write_en),
    .mem_data_in(mem_data_in), .mem_busy(mem_busy),
    .dma_bus_sel(dma_bus_sel), .dma_halt(dma_halt), .dma_addr(dma_addr),
    .dma_data_out(dma_data_out), .dma_read_en(dma_read_en), .dma_write_en(dma_write_en),
    .dma_busy(dma_busy), .dma_done(dma_done)
  );

  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Source memory contents: page 03 holds i^A5.
  function automatic logic [7:0] memval(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] - 8'h03);
  endfunction

  // mem_ctrl model with one cycle of read latency.
  always @(posedge clk) begin
    if (dma_read_en) mem_data_in <= memval(dma_addr);
    busy_q <= mem_busy;
  end

  // Monitor: pop the scoreboard on strobes and track halt length and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      halt_cnt = 0;
    end else begin
      if (dma_read_en || dma_write_en) check("strobe_excl", {31'd0, dma_read_en & dma_write_en}, 32'd0);
      if (busy_q) check("strobe_after_busy", {31'd0, dma_read_en | dma_write_en}, 32'd0);
      if (dma_read_en) begin
        if (rd_q.size() == 0) check("rd_extra", dma_addr, 32'hFFFF_FFFF);
        else check("rd_addr", dma_addr, rd_q.pop_front());
      end
      if (dma_write_en) begin
        check("wr_addr", dma_addr, 16'h2004);
        if (wr_q.size() == 0) check("wr_extra", dma_data_out, 32'hFFFF_FFFF);
        else check("wr_data", dma_data_out, wr_q.pop_front());
      end
      if (dma_done) done_cnt++;
      if (dma_halt) halt_cnt++;
      else if (halt_cnt != 0) begin
        last_halt = halt_cnt;
        halt_cnt = 0;
      end
    end
  end

  task automatic trigger(input logic [7:0] p);
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      rd_q.push_back({p, 8'(i)});
      wr_q.push_back(memval({p, 8'(i)}));
    end
    cpu_addr_in = 16'h4014;
    cpu_data_in = p;
    cpu_write_en = 1'b1;
    @(negedge clk);
    cpu_write_en = 1'b0;
    cpu_addr_in = 16'd0;
    #1;
    check("start_state", {dma_halt, dma_bus_sel, dma_busy, dma_read_en, dma_write_en, dma_done}, 6'b111000);
  endtask

  task automatic wait_done(input int exp_halt);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_seen", done_cnt - d0, 1);
    @(negedge clk);
    #1;
    check("bus_released", {dma_halt, dma_bus_sel, dma_busy, dma_done}, 4'b0000);
    check("halt_len", last_halt, exp_halt);
    check("rd_q_empty", rd_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
  endtask

  task automatic busy_driver();
    int w = 0;
    int t = 0;
    while (w < 10 && t < 2000) begin
      @(negedge clk);
      t++;
      if (dma_write_en) w++;
    end
    mem_busy = 1'b1;
    repeat (5) @(negedge clk);
    mem_busy = 1'b0;
    t = 0;
    while (!(dma_read_en && dma_addr[7:0] == 8'd200) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    mem_busy = 1'b1;
    repeat (3) @(negedge clk);
    mem_busy = 1'b0;
  endtask

  initial begin
    int d;
    int t;
    repeat (3) @(negedge clk);
    check("reset_outputs", {dma_bus_sel, dma_halt, dma_addr, dma_data_out, dma_read_en,
                            dma_write_en, dma_busy, dma_done}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Page 03: data A5, A4, ..., 5A.
    trigger(8'h03);
    wait_done(770);

    // Page 07: reads at 0700..07FF, in order.
    trigger(8'h07);
    wait_done(770);

    // mem_busy stalls in RD of index 10 and in WR of index 200.
    fork
      begin trigger(8'h01); wait_done(778); end
      busy_driver();
    join

    // A second trigger during the transfer is ignored.
    d = done_cnt;
    fork
      begin trigger(8'h02); wait_done(770); end
      begin
        repeat (100) @(negedge clk);
        cpu_addr_in = 16'h4014;
        cpu_data_in = 8'h05;
        cpu_write_en = 1'b1;
        @(negedge clk);
        cpu_write_en = 1'b0;
        cpu_addr_in = 16'd0;
      end
    join
    repeat (30) @(negedge clk);
    #1;
    check("single_done", done_cnt - d, 1);
    check("no_retrigger", {dma_halt, dma_busy}, 2'b00);

    // Reset at index 100, then a fresh trigger restarts from index 0.
    fork
      trigger(8'h04);
      begin
        t = 0;
        while (!(dma_read_en && dma_addr == 16'h0464) && t < 2000) begin
          @(negedge clk);
          t++;
        end
        check("reset_point_seen", {dma_read_en, dma_addr}, {1'b1, 16'h0464});
        rst = 1'b0;
        #1;
        check("reset_mid_outputs", {dma_bus_sel, dma_halt, dma_addr, dma_data_out, dma_read_en,
                                    dma_write_en, dma_busy, dma_done}, 32'd0);
      end
    join
    rd_q.delete();
    wr_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    trigger(8'h06);
    wait_done(770);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
